// File: rtl/hazard1_sram8_bridge.sv
// rtl/hazard1_sram8_bridge.sv - hazard1 pipelined memory port served from a byte-wide async SRAM
// Each core word is moved as up to four byte strobes with programmable wait states.
module hazard1_sram8_bridge #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_wen,
  input  logic              mem_ren,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, RD, WR, WREC} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        wait_q, wait_d;
  logic [ADDR_W-3:0] word_q;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;
  logic [23:0]       rbuf_q;
  logic              accept;
  logic              capture;
  logic              strobe_done;
  logic [2:0]        first_lane;
  logic [2:0]        next_lane;
  logic              unused_addr;

  // Word access only: low address bits and anything above the SRAM window are dropped.
  assign unused_addr = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

  // Returns {found, lane} for the lowest set bit of m.
  function automatic logic [2:0] lowest_lane(input logic [3:0] m);
    casez (m)
      4'b???1: lowest_lane = 3'b100;
      4'b??10: lowest_lane = 3'b101;
      4'b?100: lowest_lane = 3'b110;
      4'b1000: lowest_lane = 3'b111;
      default: lowest_lane = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] lanes_above(input logic [1:0] i);
    case (i)
      2'd0:    lanes_above = 4'b1110;
      2'd1:    lanes_above = 4'b1100;
      2'd2:    lanes_above = 4'b1000;
      default: lanes_above = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // mem_stall and SRAM strobes decode only registered state, so the core never sees
  // a combinational path from its own request back into mem_stall.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    accept      = 1'b0;
    capture     = 1'b0;
    mem_stall   = 1'b1;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    strobe_done = (wait_q == WS);
    first_lane  = lowest_lane(mem_wen);
    next_lane   = lowest_lane(wen_q & lanes_above(idx_q));

    unique case (state_q)
      IDLE: begin
        mem_stall = 1'b0;
        if (first_lane[2]) begin
          accept  = 1'b1;
          state_d = WR;
          idx_d   = first_lane[1:0];
          wait_d  = 4'd0;
        end else if (mem_ren) begin
          accept  = 1'b1;
          state_d = RD;
          idx_d   = 2'd0;
          wait_d  = 4'd0;
        end
      end
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (strobe_done) begin
          capture = 1'b1;
          wait_d  = 4'd0;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      WR: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        if (strobe_done) begin
          state_d = WREC;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      WREC: begin
        // Address and data stay driven one cycle past the we_n rise for hold time.
        sram_dq_oe = 1'b1;
        if (next_lane[2]) begin
          state_d = WR;
          idx_d   = next_lane[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= 2'd0;
      wait_q    <= 4'd0;
      word_q    <= '0;
      wen_q     <= 4'd0;
      wdata_q   <= 32'd0;
      rbuf_q    <= 24'd0;
      mem_rdata <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      wait_q <= wait_d;
      if (accept) begin
        word_q  <= mem_addr[ADDR_W-1:2];
        wen_q   <= mem_wen;
        wdata_q <= mem_wdata;
      end
      // Lower lanes are buffered so mem_rdata only changes once the whole word is in.
      if (capture) begin
        case (idx_q)
          2'd0:    rbuf_q[7:0]   <= sram_dq_in;
          2'd1:    rbuf_q[15:8]  <= sram_dq_in;
          2'd2:    rbuf_q[23:16] <= sram_dq_in;
          default: mem_rdata     <= {sram_dq_in, rbuf_q};
        endcase
      end
    end
  end

  assign sram_addr   = {word_q, idx_q};
  assign sram_dq_out = wdata_q[{idx_q, 3'b000} +: 8];

endmodule

// File: doc/hazard1_sram8_bridge.md
Name: hazard1_sram8_bridge

Overview:
- Memory-side neighbour of the hazard1 core.
- Consumes the core's single pipelined memory port and serves it from an external 8-bit asynchronous SRAM (byte-serial, programmable wait states).
- Drives mem_stall back to the core while a transfer is in flight; holds both the core's register file and program/data memory.

Parameters:
- ADDR_W, 19, SRAM byte-address width (sram_addr width); core address bits above ADDR_W ignored.
- WAIT_STATES, 1, extra cycles per byte strobe; legal 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_addr  in  32  core byte address (address phase)
- mem_wen  in  4  core byte write strobes (address phase)
- mem_ren  in  1  core read request (address phase)
- mem_wdata  in  32  core write data, valid with mem_wen (address phase)
- mem_rdata  out  32  read data (data phase)
- mem_stall  out  1  core hold; data phase not complete
- sram_addr  out  ADDR_W  SRAM byte address
- sram_dq_out  out  8  SRAM write data
- sram_dq_oe  out  1  tristate enable for sram_dq_out
- sram_dq_in  in  8  SRAM read data
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low

Behaviour:
- Reset: clk single clock; rst asynchronous, active-high (already decided).
- Reset values: mem_rdata=0, mem_stall=0, sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, FSM=IDLE.
- Protocol: AHB-lite-like pipelining.
  - Request accepted on any rising edge where mem_stall=0 and (mem_ren | |mem_wen); addr, wen, ren, wdata latched.
  - The core holds its next address phase stable while mem_stall=1.
- mem_stall is decoded from registered FSM state only; no combinational path from mem_* inputs (avoids a loop through the core).
- Priority: |mem_wen overrides mem_ren. A cycle with neither, while mem_stall=0, is idle and the next cycle has mem_stall=0.
- FSM states: IDLE, RD, WR, WREC.
  - IDLE --read accepted--> RD byte 0. IDLE --write accepted--> WR at lowest set wen bit.
  - RD: ce_n=0, oe_n=0, sram_addr={addr[ADDR_W-1:2],i}, held WAIT_STATES+1 cycles. sram_dq_in sampled into rdata byte lane i on the edge ending the last cycle. Then i+1; after i=3 go to IDLE.
  - WR: ce_n=0, we_n=0, dq_oe=1, dq_out=wdata[8i+7:8i], held WAIT_STATES+1 cycles, then WREC.
  - WREC: 1 cycle, we_n=1, ce_n=1, addr/data/dq_oe still held (hold time). Then next set wen bit, or IDLE if none remain. Lanes with wen=0 are skipped entirely.
- mem_stall: 1 in RD/WR/WREC, 0 in IDLE. The first IDLE cycle after a transfer is the data phase; it also accepts the next request.
- mem_rdata: holds the last completed read. Writes never modify it. Reads assemble little-endian (lane i = byte addr+i). Byte lanes update only at completion of the whole word.
- Latency, request accepted at edge N, W=WAIT_STATES:
  - Read: stall high for 4(W+1) cycles; data valid with stall low in cycle N+4(W+1)+1.
  - Write of k bytes: stall high k(W+2) cycles.
- mem_addr[1:0] ignored; word access only, byte selection via wen.
- Counters: wait counter 4 bits; byte index 2 bits. No wrap beyond index 3.
- Reset mid-transfer: outputs go to reset values immediately (asynchronous). The partial transfer is abandoned; SRAM content for unwritten lanes is undefined only for the lane whose we_n pulse was cut.

Test Plan:
- Reset then idle, W=1:
  - After reset release: stall=0, ce_n=oe_n=we_n=1, mem_rdata=0.
  - No requests for 10 cycles -> SRAM pins never toggle.
- Read, W=1, SRAM preloaded 0x100..0x103 = 11,22,33,44:
  - mem_ren, addr 0x100 -> stall high exactly 8 cycles, sram_addr steps 0x100..0x103 (2 cycles each).
  - Next cycle: stall=0, mem_rdata=0x44332211.
- Full write, W=0:
  - wen=0xF, wdata 0xDEADBEEF, addr 0x40 -> stall 8 cycles; four we_n pulses 1 cycle wide, each followed by a recovery cycle.
  - Read back 0x40 -> 0xDEADBEEF.
- Partial write:
  - wen=0x4, wdata 0x00AA0000, addr 0x40 -> single pulse at sram_addr 0x42, dq_out=0xAA, stall W+2 cycles.
  - Read back -> 0xDEAABEEF; mem_rdata unchanged between write and read.
- Back-to-back requests:
  - Read presented while the previous write is stalled -> accepted on the first stall-low edge; no idle cycle inserted.
  - Write-then-read ordering preserved.
- Reset mid-read (rst asserted during byte 2) -> same-cycle ce_n=oe_n=1, stall=0, mem_rdata=0. A post-reset read completes normally.
